// File: rtl/pipeline_hazard_ctrl.sv
// Issue/hazard controller for a three-stage IF-ID-EX pipeline: per-register latency
// scoreboard, branch flush sequencing and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int NREGS        = 32,
  parameter int REG_W        = 5,
  parameter int LAT_W        = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_used,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr_en,
  input  logic [LAT_W-1:0] id_latency,
  input  logic             ex_branch_taken,
  output logic             issue,
  output logic             stall_if,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state;
  logic [FC_W-1:0]  fcnt;
  logic [LAT_W-1:0] cnt [1:NREGS-1];
  logic [NREGS-1:0] pend;
  logic             hazard;

  // Register 0 is hard-wired zero, so its pending bit is tied low.
  always_comb begin
    pend = '0;
    for (int i = 1; i < NREGS; i++) pend[i] = |cnt[i];
  end

  assign hazard = id_valid & ((id_rs_used & pend[id_rs]) |
                              (id_rt_used & pend[id_rt]) |
                              (id_wr_en   & pend[id_rd]));
  assign busy = |pend;

  always_comb begin
    issue       = 1'b0;
    stall_if    = 1'b0;
    bubble_ex   = 1'b1;
    flush_if_id = 1'b0;
    if (reset) begin
      bubble_ex = 1'b1;
    end else if (ex_branch_taken || state == FLUSH) begin
      flush_if_id = 1'b1;
    end else if (hazard) begin
      stall_if = 1'b1;
    end else begin
      issue     = id_valid;
      bubble_ex = ~id_valid;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
      fcnt  <= '0;
    end else if (ex_branch_taken) begin
      if (FLUSH_CYCLES == 0) begin
        state <= RUN;
      end else begin
        state <= FLUSH;
        fcnt  <= FC_W'(FLUSH_CYCLES);
      end
    end else if (state == FLUSH) begin
      fcnt <= fcnt - FC_W'(1);
      if (fcnt == FC_W'(1)) state <= RUN;
    end
  end

  // A new write sets the counter and wins over the ageing decrement.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (issue && id_wr_en && id_rd == REG_W'(i)) cnt[i] <= id_latency;
        else if (pend[i]) cnt[i] <= cnt[i] - LAT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stall_count <= '0;
    else if (stall_if && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Issue/hazard controller for the three-stage fetch–decode–execute pipeline. Holds a per-register latency scoreboard. Decides each cycle whether the instruction in the IF/ID latch issues into ID/EX, stalls, or is flushed. Drives the hold and bubble controls of the IF/ID and ID/EX pipeline registers and keeps a saturating stall-cycle performance counter.

Parameters:
NREGS, 32, number of architectural registers; register 0 is hard-wired zero.
REG_W, 5, register index width; 2**REG_W == NREGS.
LAT_W, 2, width of the result-latency field and of each scoreboard counter.
FLUSH_CYCLES, 1, extra cycles after a taken branch during which wrong-path IF/ID contents are squashed.
CNT_W, 16, stall performance counter width.

Ports:
clock  in  1  pipeline clock; rising edge.
reset  in  1  asynchronous, active-high reset.
id_valid  in  1  the IF/ID latch holds a real instruction.
id_rs  in  REG_W  source register 1.
id_rs_used  in  1  the instruction reads id_rs.
id_rt  in  REG_W  source register 2.
id_rt_used  in  1  the instruction reads id_rt.
id_rd  in  REG_W  destination register.
id_wr_en  in  1  the instruction writes id_rd.
id_latency  in  LAT_W  cycles until the result can be consumed; 0 means immediately.
ex_branch_taken  in  1  Execution resolved a taken branch this cycle.
issue  out  1  the decoded instruction enters ID/EX at this edge.
stall_if  out  1  hold the PC and the IF/ID latch.
bubble_ex  out  1  load a NOP into ID/EX instead of the decoded instruction.
flush_if_id  out  1  invalidate the IF/ID latch at this edge.
busy  out  1  at least one scoreboard counter is nonzero.
stall_count  out  CNT_W  saturating count of cycles with stall_if=1.

Behaviour:
- State: cnt[1..NREGS-1], each LAT_W bits; cnt[0] is constant 0. FSM {RUN, FLUSH}. Flush down-counter fcnt. stall_count.
- Reset (asynchronous, active-high): all cnt=0, FSM=RUN, fcnt=0, stall_count=0.
- Outputs during reset: issue=0, stall_if=0, bubble_ex=1, flush_if_id=0, busy=0.
- issue, stall_if, bubble_ex and flush_if_id are combinational from the current state and the current inputs, giving zero-latency decisions. All other state is registered.
- hazard = id_valid & ((id_rs_used & cnt[id_rs]!=0) | (id_rt_used & cnt[id_rt]!=0) | (id_wr_en & cnt[id_rd]!=0)). The last term is the WAW check. Any index 0 never hazards.
- Priority 1, ex_branch_taken=1 (any state): flush_if_id=1, bubble_ex=1, issue=0, stall_if=0. Next state is FLUSH with fcnt=FLUSH_CYCLES. If FLUSH_CYCLES=0, next state stays RUN.
- Priority 2, FLUSH: flush_if_id=1, bubble_ex=1, issue=0, stall_if=0. fcnt decrements; the FSM returns to RUN after the cycle in which fcnt==1.
- Priority 3, RUN with hazard: stall_if=1, bubble_ex=1, issue=0, flush_if_id=0.
- Priority 4, RUN without hazard: issue=id_valid, bubble_ex=~id_valid, stall_if=0, flush_if_id=0.
- Scoreboard update each edge: every nonzero cnt decrements by 1.
- When issue & id_wr_en & id_rd!=0, cnt[id_rd] is set to id_latency. The set overrides the decrement on the same register.
- A flushed or stalled instruction never touches the scoreboard.
- Taken branch: in-flight counters keep decrementing, because older instructions still complete.
- stall_count increments when stall_if=1 and saturates at all-ones.
- busy = OR of all cnt.
- id_latency=0 issues without making the register pending.
- Back-to-back dependents therefore stall exactly id_latency cycles.
- Reset asserted mid-stall or mid-flush clears everything immediately; the first post-reset cycle is RUN with an empty scoreboard.

Test Plan:
1. Reset, then id_valid=1 reading r1 with r1 idle -> issue=1, bubble_ex=0 in the same cycle; stall_count=0.
2. Issue a write to r3 with id_latency=2, then next cycle an instruction reading r3 -> stall_if=1 for 2 cycles, issue=1 on the 3rd cycle; stall_count=2.
3. Write r0 with latency 3, then an instruction reading r0 -> no stall; busy stays 0.
4. Write r5 with latency 3, then next cycle a write to r5 with latency 1 (WAW) -> stalls 3 cycles, then issues; 1 cycle later cnt[r5]=0 and busy=0.
5. Stalled on r7 while ex_branch_taken pulses, with FLUSH_CYCLES=1 -> flush_if_id=1 and bubble_ex=1 for 2 cycles, issue=0 throughout; cnt[r7] continues decrementing; RUN resumes on the 3rd cycle.
6. Force 2**CNT_W+5 stall cycles, with CNT_W reduced to 4 in the bench -> stall_count holds at 15. Assert reset mid-stall -> all outputs return to reset values with no clock edge.
